instr_fetch: RTL

Instruction fetch stage of the vector-encryption core, directly upstream of the instruction decoder. It owns the 10-bit program counter and drives a synchronous instruction memory with one-cycle read latency. It presents one registered 16-bit instruction per cycle to the decoder, redirects on taken conditional jumps, and freezes on the END opcode.

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/branch_cond.sv | 28 ++
 rtl/instr_fetch.sv | 139 +++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the vector-encryption core: opcodes, jump condition
// codes, fetch FSM states and default datapath widths.
package cpu_pkg;

    localparam int unsigned DEF_ADDR_W  = 10;
    localparam int unsigned DEF_INSTR_W = 16;

    localparam logic [3:0]  OP_NOP   = 4'hD;
    localparam logic [3:0]  OP_END   = 4'hE;
    localparam logic [15:0] NOP_WORD = 16'h000D;

    typedef enum logic [1:0] {
        COND_EQ = 2'b00,
        COND_GT = 2'b01,
        COND_AL = 2'b10,
        COND_NE = 2'b11
    } cond_e;

    typedef enum logic {
        ST_RUN,
        ST_HALT
    } fetch_state_e;

endpackage

// File: rtl/branch_cond.sv
// Jump condition evaluator: decides whether a jump request is taken from the
// condition code and the CMP flags. Shared with the execute stage.
module branch_cond
    import cpu_pkg::*;
(
    input  logic       jump_req,
    input  logic [1:0] jump_cond,
    input  logic       flag_z,
    input  logic       flag_gt,
    output logic       taken
);

    logic w_cond_ok;

    always_comb begin
        w_cond_ok = 1'b0;
        case (cond_e'(jump_cond))
            COND_EQ: w_cond_ok = flag_z;
            COND_GT: w_cond_ok = flag_gt;
            COND_AL: w_cond_ok = 1'b1;
            COND_NE: w_cond_ok = !flag_z;
            default: w_cond_ok = 1'b0;
        endcase
    end

    assign taken = jump_req && w_cond_ok;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, drives a 1-cycle-latency instruction
// memory, presents registered instructions, redirects on jumps, halts on END.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned INSTR_W = DEF_INSTR_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               jump_req,
    input  logic [1:0]         jump_cond,
    input  logic [ADDR_W-1:0]  jump_target,
    input  logic               flag_z,
    input  logic               flag_gt,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               jump_taken,
    output logic               halted
);

    localparam logic [INSTR_W-1:0] NOP_I = INSTR_W'(NOP_WORD);

    fetch_state_e       r_state, w_state_nxt;
    logic [ADDR_W-1:0]  r_pc, w_pc_nxt;
    logic [ADDR_W-1:0]  r_iss, w_iss_nxt;
    logic               r_iss_v, w_iss_v_nxt;
    logic [INSTR_W-1:0] r_instr, w_instr_nxt;
    logic               r_valid, w_valid_nxt;
    logic [ADDR_W-1:0]  r_instr_pc, w_instr_pc_nxt;
    logic               r_jump_taken, w_jump_taken_nxt;
    logic               r_halted, w_halted_nxt;
    logic               w_cond_taken, w_redirect, w_end_seen;

    branch_cond u_branch_cond (
        .jump_req  (jump_req),
        .jump_cond (jump_cond),
        .flag_z    (flag_z),
        .flag_gt   (flag_gt),
        .taken     (w_cond_taken)
    );

    assign w_redirect = (r_state == ST_RUN) && w_cond_taken;
    assign w_end_seen = r_valid && (r_instr[3:0] == OP_END);

    // A stalled fetch re-reads the in-flight address so its word is still on
    // imem_rdata when the stall drops.
    always_comb begin
        if (w_redirect)
            imem_addr = jump_target;
        else if (stall && (r_state == ST_RUN))
            imem_addr = r_iss;
        else
            imem_addr = r_pc;
    end

    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_iss_nxt        = r_iss;
        w_iss_v_nxt      = r_iss_v;
        w_instr_nxt      = r_instr;
        w_valid_nxt      = r_valid;
        w_instr_pc_nxt   = r_instr_pc;
        w_jump_taken_nxt = 1'b0;
        w_halted_nxt     = r_halted;
        case (r_state)
            ST_RUN: begin
                if (w_end_seen) begin
                    w_state_nxt  = ST_HALT;
                    w_halted_nxt = 1'b1;
                    w_instr_nxt  = NOP_I;
                    w_valid_nxt  = 1'b0;
                end else if (!stall) begin
                    if (w_cond_taken) begin
                        w_pc_nxt         = jump_target + ADDR_W'(1);
                        w_iss_nxt        = jump_target;
                        w_iss_v_nxt      = 1'b1;
                        w_instr_nxt      = NOP_I;
                        w_valid_nxt      = 1'b0;
                        w_jump_taken_nxt = 1'b1;
                    end else begin
                        w_iss_nxt   = r_pc;
                        w_pc_nxt    = r_pc + ADDR_W'(1);
                        w_iss_v_nxt = 1'b1;
                        if (r_iss_v) begin
                            w_instr_nxt    = imem_rdata;
                            w_instr_pc_nxt = r_iss;
                            w_valid_nxt    = 1'b1;
                        end else begin
                            w_instr_nxt = NOP_I;
                            w_valid_nxt = 1'b0;
                        end
                    end
                end
            end
            ST_HALT: begin
                w_instr_nxt = NOP_I;
                w_valid_nxt = 1'b0;
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_RUN;
            r_pc         <= '0;
            r_iss        <= '0;
            r_iss_v      <= 1'b0;
            r_instr      <= NOP_I;
            r_valid      <= 1'b0;
            r_instr_pc   <= '0;
            r_jump_taken <= 1'b0;
            r_halted     <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_iss        <= w_iss_nxt;
            r_iss_v      <= w_iss_v_nxt;
            r_instr      <= w_instr_nxt;
            r_valid      <= w_valid_nxt;
            r_instr_pc   <= w_instr_pc_nxt;
            r_jump_taken <= w_jump_taken_nxt;
            r_halted     <= w_halted_nxt;
        end
    end

    assign instr       = r_instr;
    assign instr_valid = r_valid;
    assign instr_pc    = r_instr_pc;
    assign jump_taken  = r_jump_taken;
    assign halted      = r_halted;

endmodule
